crack_result_collector: RTL and testbench

//  Downstream of the parallel RC4 key-search cores: watches each core's found/not_found,

---
 rtl/crack_result_collector.sv | 132 +++++++++++++
 tb/tb_crack_result_collector.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crack_result_collector.sv
// Collects results from parallel RC4 key-search cores: picks the first winner, halts all
// cores, latches key and search time, then streams the winner's decrypted message out.
module crack_nf_lane (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic not_found,
  output logic nf_seen
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)              nf_seen <= 1'b0;
    else if (en && not_found)  nf_seen <= 1'b1;
endmodule

module crack_result_collector #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24,
  parameter int MSG_LEN   = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_CORES-1:0]       found,
  input  logic [NUM_CORES-1:0]       not_found,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  input  logic [NUM_CORES*8-1:0]     msg_q,
  output logic [ADDR_W-1:0]          msg_address,
  output logic                       halt,
  output logic [KEY_W-1:0]           result_key,
  output logic [1:0]                 winner_idx,
  output logic [31:0]                elapsed,
  output logic                       found_any,
  output logic                       all_failed,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       done
);
  typedef enum logic [2:0] {SEARCH, RD_WAIT, STREAM, DONE_S, FAIL_S} state_t;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  state_t               state, state_nxt;
  logic [NUM_CORES-1:0] nf_seen;
  logic [1:0]           pick;
  logic                 any_found, all_nf;
  logic                 in_search, load, accept;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    crack_nf_lane u_lane (
      .clock     (clock),
      .reset_n   (reset_n),
      .en        (in_search),
      .not_found (not_found[i]),
      .nf_seen   (nf_seen[i])
    );
  end

  // Lowest asserted index wins a simultaneous report.
  always_comb begin
    pick = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (found[i]) pick = 2'(i);
  end

  assign any_found = |found;
  assign all_nf    = &(nf_seen | not_found);

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= SEARCH;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (any_found)   state_nxt = RD_WAIT;
               else if (all_nf) state_nxt = FAIL_S;
      RD_WAIT: state_nxt = STREAM;
      STREAM:  if (out_valid && out_ready) state_nxt = out_last ? DONE_S : RD_WAIT;
      DONE_S:  state_nxt = DONE_S;
      FAIL_S:  state_nxt = FAIL_S;
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    in_search = (state == SEARCH);
    load      = (state == STREAM) && !out_valid;
    accept    = (state == STREAM) && out_valid && out_ready;
    done      = (state == DONE_S);
  end

  // Memory q is valid in the first STREAM cycle; it is captured there and held until accepted.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      msg_address <= '0;
      halt        <= 1'b0;
      result_key  <= '0;
      winner_idx  <= '0;
      elapsed     <= '0;
      found_any   <= 1'b0;
      all_failed  <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      if (in_search) begin
        if (any_found) begin
          result_key  <= core_key[int'(pick)*KEY_W +: KEY_W];
          winner_idx  <= pick;
          halt        <= 1'b1;
          found_any   <= 1'b1;
          msg_address <= '0;
        end else begin
          if (all_nf) begin
            all_failed <= 1'b1;
            halt       <= 1'b1;
          end
          if (elapsed != '1) elapsed <= elapsed + 32'd1;
        end
      end
      if (load) begin
        out_data  <= msg_q[int'(winner_idx)*8 +: 8];
        out_last  <= (msg_address == LAST_ADDR);
        out_valid <= 1'b1;
      end
      if (accept) begin
        out_valid <= 1'b0;
        if (!out_last) msg_address <= msg_address + 1'b1;
      end
    end
endmodule

// File: tb/tb_crack_result_collector.sv
// Scenario bench for crack_result_collector: random keys, delays and stalls checked
// against a simple per-scenario model of winner choice, timing and message order.
module tb_crack_result_collector;
  localparam int NC = 4, KW = 24, ML = 32, AW = 5;

  logic              clock, reset_n;
  logic [NC-1:0]     found, not_found;
  logic [NC*KW-1:0]  core_key;
  logic [NC*8-1:0]   msg_q;
  logic [AW-1:0]     msg_address;
  logic              halt, found_any, all_failed, out_valid, out_ready, out_last, done;
  logic [KW-1:0]     result_key;
  logic [1:0]        winner_idx;
  logic [31:0]       elapsed;
  logic [7:0]        out_data;

  logic [7:0]        mem [NC][ML];
  logic [KW-1:0]     keys [NC];
  int                checks = 0, errors = 0;

  crack_result_collector #(.NUM_CORES(NC), .KEY_W(KW), .MSG_LEN(ML), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .found(found), .not_found(not_found),
    .core_key(core_key), .msg_q(msg_q), .msg_address(msg_address), .halt(halt),
    .result_key(result_key), .winner_idx(winner_idx), .elapsed(elapsed),
    .found_any(found_any), .all_failed(all_failed), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read decrypted memories, one per core.
  always @(posedge clock)
    for (int i = 0; i < NC; i++) msg_q[i*8 +: 8] <= mem[i][msg_address];

  function automatic int lowest(input logic [NC-1:0] m);
    for (int i = 0; i < NC; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic fill(input int text_core);
    for (int c = 0; c < NC; c++) begin
      keys[c] = KW'($urandom);
      core_key[c*KW +: KW] = keys[c];
      for (int k = 0; k < ML; k++)
        mem[c][k] = (c == text_core) ? 8'(8'h61 + k) : 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; found = '0; not_found = '0; out_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({halt, found_any, all_failed, out_valid, out_last, done} !== 6'b0 ||
        result_key !== '0 || winner_idx !== 2'd0 || elapsed !== 32'd0 ||
        msg_address !== '0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got halt=%b key=%h el=%0d addr=%0d ov=%b done=%b exp all zero",
               halt, result_key, elapsed, msg_address, out_valid, done);
    end
  endtask

  task automatic test_stream(input int w, input int duty, input int stop_at);
    int k = 0, cyc = 0;
    logic stalled = 1'b0, pl = 1'b0;
    logic [7:0] pd = '0;
    while (k < stop_at && cyc < 3000) begin
      @(negedge clock); cyc++;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          errors++;
          $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   out_valid, out_data, out_last, pd, pl);
        end
      end
      out_ready = ($urandom_range(99) < duty);
      stalled = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          checks++;
          if (out_data !== mem[w][k] || out_last !== (k == ML - 1)) begin
            errors++;
            $display("FAIL stream_byte%0d got d=%h l=%b exp d=%h l=%b",
                     k, out_data, out_last, mem[w][k], (k == ML - 1));
          end
          k++;
        end else begin
          stalled = 1'b1; pd = out_data; pl = out_last;
        end
      end
    end
    checks++;
    if (k < stop_at) begin
      errors++;
      $display("FAIL stream_timeout got %0d bytes exp %0d", k, stop_at);
    end
    if (stop_at == ML) begin
      @(negedge clock); out_ready = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (done !== 1'b1 || msg_address !== AW'(ML - 1) || out_valid !== 1'b0 || halt !== 1'b1) begin
        errors++;
        $display("FAIL stream_end got done=%b addr=%0d ov=%b halt=%b exp 1 %0d 0 1",
                 done, msg_address, out_valid, halt, ML - 1);
      end
    end
  endtask

  task automatic test_first_found();
    do_reset();
    fill(2);
    keys[2] = 24'h001234; core_key[2*KW +: KW] = keys[2];
    repeat (1000) @(posedge clock);
    @(negedge clock); found = 4'b0100;
    @(negedge clock); found = '0;
    checks++;
    if (halt !== 1'b1 || winner_idx !== 2'd2 || result_key !== 24'h001234 ||
        elapsed !== 32'd1000 || found_any !== 1'b1) begin
      errors++;
      $display("FAIL first_found got halt=%b w=%0d key=%h el=%0d fa=%b exp 1 2 001234 1000 1",
               halt, winner_idx, result_key, elapsed, found_any);
    end
    test_stream(2, 100, ML);
  endtask

  task automatic test_same_cycle_stall();
    int d = $urandom_range(5, 40);
    do_reset();
    fill(1);
    repeat (d) @(posedge clock);
    @(negedge clock); found = 4'b1010;
    @(negedge clock); found = '0;
    checks++;
    if (winner_idx !== 2'd1 || result_key !== keys[1] || elapsed !== 32'(d)) begin
      errors++;
      $display("FAIL same_cycle got w=%0d key=%h el=%0d exp 1 %h %0d",
               winner_idx, result_key, elapsed, keys[1], d);
    end
    test_stream(1, 30, ML);
  endtask

  task automatic test_random_winner();
    for (int it = 0; it < 6; it++) begin
      int d = $urandom_range(1, 60);
      logic [NC-1:0] f = NC'($urandom_range(1, 15));
      int w = lowest(f);
      do_reset();
      fill(-1);
      not_found = NC'($urandom) & 4'b0111;
      repeat (d) @(posedge clock);
      @(negedge clock); found = f; not_found = '0;
      @(negedge clock); found = '0;
      checks++;
      if (winner_idx !== 2'(w) || result_key !== keys[w] || elapsed !== 32'(d) ||
          halt !== 1'b1 || found_any !== 1'b1 || all_failed !== 1'b0) begin
        errors++;
        $display("FAIL rand_winner f=%b got w=%0d key=%h el=%0d exp %0d %h %0d",
                 f, winner_idx, result_key, elapsed, w, keys[w], d);
      end
      found = ~f; not_found = '1;
      repeat (4) @(negedge clock);
      found = '0; not_found = '0;
      checks++;
      if (winner_idx !== 2'(w) || result_key !== keys[w] || elapsed !== 32'(d) || all_failed !== 1'b0) begin
        errors++;
        $display("FAIL ignore_after got w=%0d key=%h el=%0d af=%b exp %0d %h %0d 0",
                 winner_idx, result_key, elapsed, all_failed, w, keys[w], d);
      end
    end
  endtask

  task automatic test_found_beats_fail();
    do_reset();
    fill(-1);
    not_found = 4'b0111;
    @(negedge clock); not_found = '0;
    repeat (3) @(negedge clock);
    found = 4'b1000; not_found = 4'b1000;
    @(negedge clock); found = '0; not_found = '0;
    checks++;
    if (winner_idx !== 2'd3 || result_key !== keys[3] || all_failed !== 1'b0 || found_any !== 1'b1) begin
      errors++;
      $display("FAIL found_wins got w=%0d af=%b fa=%b exp 3 0 1", winner_idx, all_failed, found_any);
    end
  endtask

  task automatic test_all_failed();
    do_reset();
    fill(-1);
    for (int t = 1; t <= 45; t++) begin
      not_found = (t == 10) ? 4'b0001 : (t == 20) ? 4'b0010 :
                  (t == 30) ? 4'b0100 : (t == 40) ? 4'b1000 : 4'b0000;
      @(negedge clock);
      if (t == 39 || t == 40 || t == 45) begin
        checks++;
        if (all_failed !== (t >= 40) || halt !== (t >= 40) || out_valid !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL all_failed_t%0d got af=%b halt=%b ov=%b done=%b exp af=%b",
                   t, all_failed, halt, out_valid, done, (t >= 40));
        end
      end
    end
    not_found = '0; found = 4'b0001; out_ready = 1'b1;
    repeat (6) @(negedge clock);
    found = '0;
    checks++;
    if (found_any !== 1'b0 || all_failed !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL fail_terminal got fa=%b af=%b ov=%b done=%b exp 0 1 0 0",
               found_any, all_failed, out_valid, done);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    fill(0);
    repeat (3) @(posedge clock);
    @(negedge clock); found = 4'b0001;
    @(negedge clock); found = '0;
    test_stream(0, 100, 10);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({halt, found_any, all_failed, out_valid, out_last, done} !== 6'b0 ||
        result_key !== '0 || elapsed !== 32'd0 || msg_address !== '0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got halt=%b ov=%b d=%h addr=%0d el=%0d exp all zero",
               halt, out_valid, out_data, msg_address, elapsed);
    end
    @(negedge clock); reset_n = 1'b1; out_ready = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    checks++;
    if (elapsed !== 32'd5 || halt !== 1'b0 || found_any !== 1'b0) begin
      errors++;
      $display("FAIL restart got el=%0d halt=%b fa=%b exp 5 0 0", elapsed, halt, found_any);
    end
  endtask

  initial begin
    reset_n = 1'b0; found = '0; not_found = '0; out_ready = 1'b0; core_key = '0;
    fill(-1);
    test_reset();
    test_first_found();
    test_same_cycle_stall();
    test_random_winner();
    test_found_beats_fail();
    test_all_failed();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
